// File: rtl/sum_accumulator.sv
// sum_accumulator: buffers 9-bit adder results in a small FIFO and folds each one
// into a 16-bit running accumulator using a two-cycle, byte-serial add engine.
module sum_accumulator #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  in_sum,
    input  logic        clear,
    input  logic        byte_sel,
    output logic [15:0] acc,
    output logic [7:0]  count,
    output logic        overflow,
    output logic        busy,
    output logic [7:0]  byte_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    typedef enum logic [1:0] {
        StIdle,
        StAddLo,
        StAddHi
    } state_e;

    state_e      state_q, state_d;
    logic [8:0]  mem_q [DEPTH];
    // Extra MSB on each pointer tells full from empty when the index bits match.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [8:0]  op_q, op_d;
    logic        c_q, c_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  count_q, count_d;
    logic        ovf_q, ovf_d;

    logic        full, empty, push, pop, flush;
    logic [8:0]  lo_sum, hi_sum;

    // rst behaves exactly like clear for everything in the block.
    assign flush = rst | clear;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Registered-state only, so a same-cycle pop never re-opens a full FIFO.
    assign in_ready = !full;
    assign push     = in_valid && !full && !flush;

    // Byte-serial halves of the ripple add; the low carry is held in c between cycles.
    assign lo_sum = {1'b0, acc_q[7:0]} + {1'b0, op_q[7:0]};
    assign hi_sum = {1'b0, acc_q[15:8]} + {8'd0, op_q[8]} + {8'd0, c_q};

    assign acc      = acc_q;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign busy     = !empty || (state_q != StIdle);
    assign byte_out = byte_sel ? acc_q[15:8] : acc_q[7:0];

    // Next-state for the FSM, FIFO pointers and accumulator datapath; flush wins last.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        c_d      = c_q;
        acc_d    = acc_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        pop      = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    op_d    = mem_q[rd_ptr_q[AW-1:0]];
                    state_d = StAddLo;
                end
            end
            StAddLo: begin
                {c_d, acc_d[7:0]} = lo_sum;
                state_d           = StAddHi;
            end
            StAddHi: begin
                acc_d[15:8] = hi_sum[7:0];
                if (hi_sum[8]) begin
                    ovf_d = 1'b1;
                end
                if (count_q != 8'hFF) begin
                    count_d = count_q + 8'd1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        if (flush) begin
            state_d  = StIdle;
            op_d     = '0;
            c_d      = 1'b0;
            acc_d    = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // State, pointer and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            c_q      <= 1'b0;
            acc_q    <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            c_q      <= c_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_sum;
        end
    end

endmodule
